// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline hazard control bus.
// Groups the hazard-detection inputs from the pipeline registers with the
// stall/flush controls sent back to them. The optional stall_cnt signal
// appears only when STALL_CNT_EN is defined.
interface pipe_hazard_ctrl_if;

   // Hazard-detection inputs sampled from the pipeline registers
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        idex_memread;
   logic [4:0]  idex_rt;
   logic        branch_taken;
   logic        jump;
   logic        mem_req;
   logic        mem_ack;

   // Stall and flush controls returned to the pipeline
   logic        pc_write;
   logic        ifid_write;
   logic        ifid_flush;
   logic        idex_flush;
   logic        exmem_flush;
   logic        pipe_freeze;
   logic [1:0]  state;
`ifdef STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   // Pipeline side: drives the hazard inputs, observes the controls
   modport master (
      output id_rs, id_rt, idex_memread, idex_rt,
      output branch_taken, jump, mem_req, mem_ack,
      input  pc_write, ifid_write, ifid_flush, idex_flush,
      input  exmem_flush, pipe_freeze, state
`ifdef STALL_CNT_EN
      , input stall_cnt
`endif
   );

   // Controller side: observes the hazard inputs, drives the controls
   modport slave (
      input  id_rs, id_rt, idex_memread, idex_rt,
      input  branch_taken, jump, mem_req, mem_ack,
      output pc_write, ifid_write, ifid_flush, idex_flush,
      output exmem_flush, pipe_freeze, state
`ifdef STALL_CNT_EN
      , output stall_cnt
`endif
   );

endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a five-stage pipeline.
// Handles three kinds of events, in priority order:
//   - data-memory wait  : freeze the whole pipeline until mem_ack, or halt
//                         once MEM_TIMEOUT wait cycles pass without an ack
//   - redirect          : taken branch or jump, flush IF/ID, ID/EX, EX/MEM
//   - load-use          : one bubble inserted into ID/EX
// Only the state and a 4-bit wait counter are registered; every control
// output is combinational in the state and the inputs.
// Optional feature macro: STALL_CNT_EN adds a saturating 16-bit count of
// cycles with pc_write low.
module pipe_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 15
) (
   input logic          clk,
   input logic          rst_n,
   pipe_hazard_ctrl_if.slave hz
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_FLUSH    = 2'd1,
      ST_MEM_WAIT = 2'd2,
      ST_HALT     = 2'd3
   } state_t;

   // Last counter value before the wait gives up. Out-of-range timeouts are
   // clamped into 1..15 so the 4-bit counter can always reach the limit.
   localparam int TIMEOUT_CLAMPED = (MEM_TIMEOUT < 1)  ? 1  :
                                    (MEM_TIMEOUT > 15) ? 15 : MEM_TIMEOUT;
   localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT_CLAMPED - 1);

   state_t     state_q;
   logic [3:0] wait_cnt;

   logic mem_wait_evt;
   logic redirect_evt;
   logic load_use_evt;

   // Event decode shared by the state register and the output logic.
   // A load-use hazard needs a real destination: register 0 is hard-wired
   // to zero, so a load into it can never create a dependency.
   assign mem_wait_evt = hz.mem_req & ~hz.mem_ack;
   assign redirect_evt = hz.branch_taken | hz.jump;
   assign load_use_evt = hz.idex_memread
                         & (hz.idex_rt != 5'd0)
                         & ((hz.idex_rt == hz.id_rs) | (hz.idex_rt == hz.id_rt));

   // State register and wait counter; memory wait outranks redirect, and
   // the counter only advances while a memory access is outstanding.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_RUN;
         wait_cnt <= 4'd0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (mem_wait_evt) begin
                  wait_cnt <= 4'd0;
                  state_q  <= ST_MEM_WAIT;
               end else if (redirect_evt) begin
                  state_q  <= ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               state_q <= ST_RUN;
            end
            ST_MEM_WAIT: begin
               wait_cnt <= wait_cnt + 4'd1;
               if (hz.mem_ack) begin
                  state_q <= ST_RUN;
               end else if (wait_cnt == WAIT_LAST) begin
                  state_q <= ST_HALT;
               end
            end
            ST_HALT: begin
               state_q <= ST_HALT;
            end
            default: begin
               state_q <= ST_RUN;
            end
         endcase
      end
   end

   // Control outputs from the current state and inputs. Reset gates every
   // control back to its default so a freeze cannot outlive the reset pulse,
   // whatever the pipeline is still presenting on the inputs.
   always_comb begin
      hz.pc_write    = 1'b1;
      hz.ifid_write  = 1'b1;
      hz.ifid_flush  = 1'b0;
      hz.idex_flush  = 1'b0;
      hz.exmem_flush = 1'b0;
      hz.pipe_freeze = 1'b0;
      if (rst_n) begin
         case (state_q)
            ST_RUN: begin
               if (mem_wait_evt) begin
                  hz.pipe_freeze = 1'b1;
                  hz.pc_write    = 1'b0;
                  hz.ifid_write  = 1'b0;
               end else if (redirect_evt) begin
                  hz.ifid_flush  = 1'b1;
                  hz.idex_flush  = 1'b1;
                  hz.exmem_flush = 1'b1;
               end else if (load_use_evt) begin
                  hz.pc_write    = 1'b0;
                  hz.ifid_write  = 1'b0;
                  hz.idex_flush  = 1'b1;
               end
            end
            ST_MEM_WAIT: begin
               if (!hz.mem_ack) begin
                  hz.pipe_freeze = 1'b1;
                  hz.pc_write    = 1'b0;
                  hz.ifid_write  = 1'b0;
               end
            end
            ST_HALT: begin
               hz.pipe_freeze = 1'b1;
               hz.pc_write    = 1'b0;
               hz.ifid_write  = 1'b0;
            end
            default: begin
               hz.pc_write = 1'b1;
            end
         endcase
      end
   end

   assign hz.state = state_q;

`ifdef STALL_CNT_EN
   logic [15:0] stall_cnt_q;

   // Saturating count of cycles in which the PC was held
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= 16'd0;
      end else if (!hz.pc_write && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign hz.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl.
// Directed scenarios for load-use, jump, memory wait, timeout/halt and
// simultaneous events, followed by randomized traffic with occasional
// asynchronous resets, all checked against a behavioural model.
// Define STALL_CNT_EN to also check the optional stall counter.
module tb_pipe_hazard_ctrl;

   localparam int TMO = 4;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   pipe_hazard_ctrl_if hzBus ();

   pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hzBus)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: what the pipeline is currently doing
   bit mHalted;
   bit mWaiting;
   int mWaitLen;
   bit mRecovering;
   int mStalls;

   // Expected outputs for the current cycle
   int ePc, eIfid, eFlushId, eFlushEx, eFlushMem, eFreeze, eState;

   // Observed outputs for the current cycle
   int oPc, oIfid, oFlushId, oFlushEx, oFlushMem, oFreeze, oState, oStall;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      total++;
      if (observed != expected) begin
         bad++;
         $display("[TB] FAIL %s observed=%0d expected=%0d at t=%0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelClear();
      mHalted     = 0;
      mWaiting    = 0;
      mWaitLen    = 0;
      mRecovering = 0;
      mStalls     = 0;
   endtask

   // Derive the expected outputs from the model and the present inputs,
   // sample the DUT, and compare everything
   task automatic evalAndCheck();
      bit loadUse;
      bit freezeNow;
      bit flushNow;
      bit bubbleNow;
      loadUse = hzBus.idex_memread && (hzBus.idex_rt != 0) &&
                ((hzBus.idex_rt == hzBus.id_rs) || (hzBus.idex_rt == hzBus.id_rt));
      freezeNow = 0; flushNow = 0; bubbleNow = 0;
      eState = 0;
      if (rst_n) begin
         if (mHalted) begin
            eState = 3; freezeNow = 1;
         end else if (mWaiting) begin
            eState = 2; freezeNow = !hzBus.mem_ack;
         end else if (mRecovering) begin
            eState = 1;
         end else if (hzBus.mem_req && !hzBus.mem_ack) begin
            freezeNow = 1;
         end else if (hzBus.branch_taken || hzBus.jump) begin
            flushNow = 1;
         end else if (loadUse) begin
            bubbleNow = 1;
         end
      end
      ePc       = (freezeNow || bubbleNow) ? 0 : 1;
      eIfid     = ePc;
      eFlushId  = flushNow;
      eFlushEx  = (flushNow || bubbleNow) ? 1 : 0;
      eFlushMem = flushNow;
      eFreeze   = freezeNow;

      oPc       = hzBus.pc_write;
      oIfid     = hzBus.ifid_write;
      oFlushId  = hzBus.ifid_flush;
      oFlushEx  = hzBus.idex_flush;
      oFlushMem = hzBus.exmem_flush;
      oFreeze   = hzBus.pipe_freeze;
      oState    = hzBus.state;
`ifdef STALL_CNT_EN
      oStall    = hzBus.stall_cnt;
`else
      oStall    = 0;
`endif

      checkOutput("state",       oState,    eState);
      checkOutput("pc_write",    oPc,       ePc);
      checkOutput("ifid_write",  oIfid,     eIfid);
      checkOutput("ifid_flush",  oFlushId,  eFlushId);
      checkOutput("idex_flush",  oFlushEx,  eFlushEx);
      checkOutput("exmem_flush", oFlushMem, eFlushMem);
      checkOutput("pipe_freeze", oFreeze,   eFreeze);
`ifdef STALL_CNT_EN
      checkOutput("stall_cnt",   oStall,    mStalls);
`endif
   endtask

   // Advance the model across one rising edge
   task automatic modelStep();
      if (mHalted) begin
         mHalted = 1;
      end else if (mWaiting) begin
         if (hzBus.mem_ack) begin
            mWaiting = 0;
         end else begin
            mWaitLen++;
            if (mWaitLen == TMO) begin
               mWaiting = 0;
               mHalted  = 1;
            end
         end
      end else if (mRecovering) begin
         mRecovering = 0;
      end else if (hzBus.mem_req && !hzBus.mem_ack) begin
         mWaiting = 1;
         mWaitLen = 0;
      end else if (hzBus.branch_taken || hzBus.jump) begin
         mRecovering = 1;
      end
      if (ePc == 0 && mStalls < 65535) mStalls++;
   endtask

   // One pipeline cycle: drive at the falling edge, check just after,
   // then let the rising edge update the DUT and the model
   task automatic applyStimulus(input bit memread, input int idexRt, input int idRs,
                                input int idRt, input bit bt, input bit jmp,
                                input bit req, input bit ack);
      @(negedge clk);
      hzBus.idex_memread = memread;
      hzBus.idex_rt      = 5'(idexRt);
      hzBus.id_rs        = 5'(idRs);
      hzBus.id_rt        = 5'(idRt);
      hzBus.branch_taken = bt;
      hzBus.jump         = jmp;
      hzBus.mem_req      = req;
      hzBus.mem_ack      = ack;
      #1;
      evalAndCheck();
      @(posedge clk);
      modelStep();
   endtask

   task automatic idleCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Asynchronous reset pulse placed between clock edges; outputs are
   // checked while reset is still low, with the current inputs untouched
   task automatic resetPulse();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      modelClear();
      #1;
      evalAndCheck();
      checkOutput("rst_state", oState, 0);
      checkOutput("rst_freeze", oFreeze, 0);
      hzBus.idex_memread = 0; hzBus.idex_rt = 0; hzBus.id_rs = 0; hzBus.id_rt = 0;
      hzBus.branch_taken = 0; hzBus.jump = 0; hzBus.mem_req = 0; hzBus.mem_ack = 0;
      #1;
      rst_n = 1'b1;
      @(posedge clk);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      modelClear();
      rst_n = 1'b0;
      hzBus.idex_memread = 0; hzBus.idex_rt = 0; hzBus.id_rs = 0; hzBus.id_rt = 0;
      hzBus.branch_taken = 0; hzBus.jump = 0; hzBus.mem_req = 0; hzBus.mem_ack = 0;
      #3;
      evalAndCheck();
      checkOutput("reset_state", oState, 0);
      checkOutput("reset_pc_write", oPc, 1);
      #9;
      rst_n = 1'b1;
      idleCycle();

      // Load-use on rs: exactly one bubble cycle, then normal flow
      $display("[TB] load-use scenario");
      applyStimulus(1, 5, 5, 9, 0, 0, 0, 0);
      checkOutput("lu_pc_write", oPc, 0);
      checkOutput("lu_idex_flush", oFlushEx, 1);
      idleCycle();
      checkOutput("lu_released", oPc, 1);
      // Load into register 0 never stalls
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("lu_r0_pc_write", oPc, 1);
      checkOutput("lu_r0_idex_flush", oFlushEx, 0);

      // Memory wait: three frozen cycles, released in the ack cycle
      $display("[TB] memory wait scenario");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
         checkOutput("mw_freeze", oFreeze, 1);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
      checkOutput("mw_ack_freeze", oFreeze, 0);
      checkOutput("mw_ack_state", oState, 2);
      idleCycle();
      checkOutput("mw_back_run", oState, 0);
`ifdef STALL_CNT_EN
      checkOutput("stall_cnt_4", oStall, 4);
`endif

      // Jump held for two cycles: flush once, then a quiet FLUSH cycle
      $display("[TB] jump scenario");
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
      checkOutput("jmp_ifid_flush", oFlushId, 1);
      checkOutput("jmp_exmem_flush", oFlushMem, 1);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
      checkOutput("jmp_state_flush", oState, 1);
      checkOutput("jmp_no_flush", oFlushId, 0);
      idleCycle();
      checkOutput("jmp_back_run", oState, 0);

      // Memory wait, redirect and load-use together: wait wins, redirect
      // fires once the access completes
      $display("[TB] simultaneous events scenario");
      applyStimulus(1, 7, 7, 0, 1, 0, 1, 0);
      checkOutput("sim_freeze", oFreeze, 1);
      checkOutput("sim_no_flush", oFlushMem, 0);
      applyStimulus(1, 7, 7, 0, 1, 0, 1, 1);
      checkOutput("sim_ack_flush", oFlushMem, 0);
      applyStimulus(1, 7, 7, 0, 1, 0, 0, 0);
      checkOutput("sim_redirect", oFlushMem, 1);
      idleCycle();
      idleCycle();

      // Timeout: no ack ever, halt after TMO wait cycles until reset
      $display("[TB] timeout scenario");
      for (int i = 0; i < TMO + 1; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
      checkOutput("tmo_halt", oState, 3);
      for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0, 1, 0, 1, 1);
      checkOutput("tmo_held", oState, 3);
      checkOutput("tmo_held_freeze", oFreeze, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
      resetPulse();
      idleCycle();

      // Randomized traffic with occasional asynchronous resets
      $display("[TB] random scenario");
      for (int i = 0; i < 600; i++) begin
         if ((mHalted && ($urandom % 4 == 0)) || ($urandom % 80 == 0)) begin
            resetPulse();
         end else begin
            applyStimulus(1'($urandom % 2), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          1'($urandom % 8 == 0), 1'($urandom % 8 == 0),
                          1'($urandom % 4 == 0), 1'($urandom % 2));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, maximum wait cycles for the data-memory handshake (legal 1..15).
REQ-002 SHALL have clk  input  1  pipeline clock; all state updates occur on the rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have id_rs  input  5  IF/ID instruction bits [25:21].
REQ-005 SHALL have id_rt  input  5  IF/ID instruction bits [20:16].
REQ-006 SHALL have idex_memread  input  1  ID/EX MemRead.
REQ-007 SHALL have idex_rt  input  5  ID/EX rt field.
REQ-008 SHALL have branch_taken  input  1  EX/MEM Branch AND zero flag.
REQ-009 SHALL have jump  input  1  EX/MEM jump.
REQ-010 SHALL have mem_req  input  1  EX/MEM MemRead OR MemWrite.
REQ-011 SHALL have mem_ack  input  1  data memory completes the access this cycle.
REQ-012 SHALL have pc_write  output  1  PC load enable.
REQ-013 SHALL have ifid_write  output  1  IF/ID load enable.
REQ-014 SHALL have ifid_flush  output  1  zero IF/ID at the next edge.
REQ-015 SHALL have idex_flush  output  1  zero ID/EX control fields at the next edge.
REQ-016 SHALL have exmem_flush  output  1  zero EX/MEM control fields at the next edge.
REQ-017 SHALL have pipe_freeze  output  1  hold ID/EX, EX/MEM and MEM/WB.
REQ-018 SHALL have state  output  2  current state: RUN=0, FLUSH=1, MEM_WAIT=2, HALT=3.

Function
REQ-019 SHALL register only the state and a 4-bit wait counter; all outputs SHALL be combinational in the current state and the inputs.
REQ-020 SHALL use these default outputs: pc_write=1, ifid_write=1, all flush outputs 0, pipe_freeze=0.
REQ-021 In RUN, SHALL evaluate the events in priority order: memory wait, then redirect, then load-use.
REQ-022 Memory wait: in RUN with mem_req=1 and mem_ack=0, SHALL drive pipe_freeze=1, pc_write=0 and ifid_write=0, clear the counter, and move to MEM_WAIT.
REQ-023 In RUN with mem_req=1 and mem_ack=1, SHALL raise no wait.
REQ-024 In MEM_WAIT, SHALL drive the same freeze outputs every cycle and increment the counter.
REQ-025 On mem_ack in MEM_WAIT, SHALL release the freeze in that same cycle and return to RUN.
REQ-026 When the counter equals MEM_TIMEOUT-1 and mem_ack=0, SHALL move to HALT.
REQ-027 SHALL ignore redirect and load-use events while in MEM_WAIT; they are re-evaluated in RUN because the pipeline is frozen.
REQ-028 Redirect: in RUN with branch_taken or jump, SHALL assert ifid_flush, idex_flush and exmem_flush, keep pc_write=1, and move to FLUSH.
REQ-029 FLUSH SHALL last exactly one cycle with default outputs, ignoring branch_taken, jump and load-use, then return to RUN.
REQ-030 Load-use: in RUN with idex_memread=1, idex_rt!=0 and idex_rt equal to id_rs or id_rt, SHALL drive pc_write=0, ifid_write=0 and idex_flush=1 for that cycle only, staying in RUN.
REQ-031 HALT SHALL drive pipe_freeze=1, pc_write=0 and ifid_write=0, and SHALL be left only by reset.
REQ-032 The state output SHALL encode only the values 0..3.

Reset
REQ-033 While rst_n=0, SHALL force state=RUN and counter=0, so outputs take default values immediately.
REQ-034 Reset asserted mid-MEM_WAIT or in HALT SHALL abandon the wait with no residual freeze.

Configuration
REQ-035 With STALL_CNT_EN defined, SHALL add output stall_cnt[15:0], counting the cycles with pc_write=0, saturating at 0xFFFF and reset to 0.
REQ-036 Without STALL_CNT_EN, the stall_cnt port and its counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-037 Load-use: idex_memread=1, idex_rt=5, id_rs=5 -> exactly one cycle of pc_write=0, ifid_write=0, idex_flush=1; with idex_rt=0 -> no stall.
REQ-038 Jump: jump=1 for 2 cycles -> first cycle asserts all three flushes and state goes to 1, second cycle shows no flushes, then state returns to 0.
REQ-039 Memory wait: mem_req=1 with mem_ack low for 3 cycles, then high -> freeze held 3 cycles, released in the ack cycle, state back to 0.
REQ-040 Timeout: MEM_TIMEOUT=4 and mem_ack never asserted -> state=3 after 4 MEM_WAIT cycles and held 20 further cycles; rst_n pulse -> state=0 with default outputs asynchronously.
REQ-041 Simultaneous events: mem_req=1, mem_ack=0, branch_taken=1 and a load-use hazard in the same cycle -> MEM_WAIT only, no flush; after the ack, the redirect flush fires.
REQ-042 With STALL_CNT_EN defined, the scenarios of REQ-037 and REQ-039 -> stall_cnt=4.
